ret_addr_monitor: RTL

- Control-flow integrity front-end sitting between the commit stage and the `circular_buffer` return-address store.
- Decodes committed instructions and pushes the link address (`buf_write_o`/`buf_data_o`) on every call.
- On every return, presents the actual target on `buf_find_o` and samples `buf_hit_i` (the buffer's `data_in_memory`).
- A miss raises a sticky violation, captures where it happened and counts it.

---
 rtl/ret_mon_pkg.sv | 19 +
 rtl/ret_mon_decode.sv | 33 +++
 rtl/ret_addr_monitor.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ret_mon_pkg.sv
// Shared types and constants for the return-address monitor.
// Optional feature macro used by the top: RET_MON_HALT_EN (adds halt_o).
package ret_mon_pkg;

    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;

    // RISC-V link registers: ra (x1) and the alternate link t0 (x5)
    localparam logic [4:0] LINK_RA = 5'd1;
    localparam logic [4:0] LINK_T0 = 5'd5;

    typedef enum logic [1:0] {IDLE, RUN, ALARM} ret_mon_state_e;
    typedef enum logic [1:0] {K_NONE, K_CALL, K_RET} ret_mon_kind_e;

    function automatic logic is_link(input logic [4:0] r);
        return (r == LINK_RA) || (r == LINK_T0);
    endfunction

endpackage

// File: rtl/ret_mon_decode.sv
// Combinational classifier: committed instruction -> CALL / RET / NONE.
// A link destination wins, so JALR x1,0(x5) is a call, never a return.
module ret_mon_decode
    import ret_mon_pkg::*;
(
    input  logic [31:0]   instr,
    output ret_mon_kind_e kind
);

    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic       unused_bits;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign rs1    = instr[19:15];

    // Only opcode/rd/rs1 matter for classification.
    assign unused_bits = ^{instr[31:20], instr[14:12]};

    // Classify the instruction; calls take priority over returns
    always_comb begin
        kind = K_NONE;
        if (opcode == OPC_JAL) begin
            if (is_link(rd)) kind = K_CALL;
        end else if (opcode == OPC_JALR) begin
            if (is_link(rd))       kind = K_CALL;
            else if (is_link(rs1)) kind = K_RET;
        end
    end

endmodule

// File: rtl/ret_addr_monitor.sv
// Return-address monitor: pushes link addresses on calls into the external
// return-address buffer and checks every return target against it.
// Optional macro RET_MON_HALT_EN adds halt_o, high while in ALARM.
module ret_addr_monitor
    import ret_mon_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              enable_i,
    input  logic              clear_i,
    input  logic              commit_valid_i,
    input  logic [31:0]       commit_instr_i,
    input  logic              commit_compressed_i,
    input  logic [ADDR_W-1:0] commit_pc_i,
    input  logic [ADDR_W-1:0] commit_target_i,
    output logic              buf_write_o,
    output logic [ADDR_W-1:0] buf_data_o,
    output logic [ADDR_W-1:0] buf_find_o,
    input  logic              buf_hit_i,
    output logic              violation_o,
    output logic [ADDR_W-1:0] violation_pc_o,
    output logic [ADDR_W-1:0] violation_target_o,
    output logic [CNT_W-1:0]  violation_cnt_o
`ifdef RET_MON_HALT_EN
    ,
    output logic              halt_o
`endif
);

    ret_mon_state_e    state_reg, state_next;
    ret_mon_kind_e     dec_kind;
    ret_mon_kind_e     s2_kind_reg;
    logic [ADDR_W-1:0] s2_pc_reg;
    logic [ADDR_W-1:0] link_reg;
    logic [ADDR_W-1:0] find_reg;
    logic              viol_reg;
    logic [ADDR_W-1:0] vpc_reg;
    logic [ADDR_W-1:0] vtgt_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  cnt_inc;

    logic capture;
    logic s2_live;
    logic miss;

    ret_mon_decode u_decode (
        .instr (commit_instr_i),
        .kind  (dec_kind)
    );

    assign capture = commit_valid_i && (state_reg != IDLE);
    // Dropping enable squashes whatever sits in stage 2 this very cycle.
    assign s2_live = enable_i && (state_reg != IDLE);
    assign miss    = s2_live && (s2_kind_reg == K_RET) && !buf_hit_i;
    assign cnt_inc = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + CNT_W'(1);

    // Stage-1 register: latch the decoded op; link/find values held between ops
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_kind_reg <= K_NONE;
            s2_pc_reg   <= '0;
            link_reg    <= '0;
            find_reg    <= '0;
        end else begin
            s2_kind_reg <= capture ? dec_kind : K_NONE;
            if (capture && dec_kind == K_CALL) begin
                link_reg <= commit_pc_i + (commit_compressed_i ? ADDR_W'(2) : ADDR_W'(4));
            end
            if (capture && dec_kind == K_RET) begin
                find_reg  <= commit_target_i;
                s2_pc_reg <= commit_pc_i;
            end
        end
    end

    // Alarm bookkeeping: a miss beats a coincident clear; first miss is captured
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            viol_reg <= 1'b0;
            vpc_reg  <= '0;
            vtgt_reg <= '0;
            cnt_reg  <= '0;
        end else if (miss) begin
            viol_reg <= 1'b1;
            cnt_reg  <= clear_i ? CNT_W'(1) : cnt_inc;
            if (!viol_reg || clear_i) begin
                vpc_reg  <= s2_pc_reg;
                vtgt_reg <= find_reg;
            end
        end else if (clear_i) begin
            viol_reg <= 1'b0;
            vpc_reg  <= '0;
            vtgt_reg <= '0;
            cnt_reg  <= '0;
        end
    end

    // Next-state logic; disabling always wins and sends the FSM to IDLE
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = viol_reg ? ALARM : RUN;
            RUN:     if (miss) state_next = ALARM;
            ALARM:   if (clear_i && !miss) state_next = RUN;
            default: state_next = IDLE;
        endcase
        if (!enable_i) state_next = IDLE;
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_reg <= IDLE;
        else         state_reg <= state_next;
    end

    assign buf_write_o        = s2_live && (s2_kind_reg == K_CALL);
    assign buf_data_o         = link_reg;
    assign buf_find_o         = find_reg;
    assign violation_o        = viol_reg;
    assign violation_pc_o     = vpc_reg;
    assign violation_target_o = vtgt_reg;
    assign violation_cnt_o    = cnt_reg;
`ifdef RET_MON_HALT_EN
    assign halt_o             = (state_reg == ALARM);
`endif

endmodule
